// File: rtl/rtc_pkg.sv
// Shared types and constants for the time-of-day counter.
package rtc_pkg;

    localparam int unsigned SEC_MOD = 60;
    localparam int unsigned MIN_MOD = 60;
    localparam int unsigned HRS_W   = 5;
    localparam int unsigned MS_W    = 6;

    typedef struct packed {
        logic [HRS_W-1:0] hrs;
        logic [MS_W-1:0]  min;
        logic [MS_W-1:0]  sec;
    } rtc_time_t;

    typedef struct packed {
        logic [HRS_W-1:0] hrs;
        logic [MS_W-1:0]  min;
    } rtc_alarm_t;

    // True when every field of t is inside its counting range.
    function automatic logic time_in_range(rtc_time_t t, int unsigned hrs_mod);
        return (32'(t.hrs) < hrs_mod) && (32'(t.min) < MIN_MOD) && (32'(t.sec) < SEC_MOD);
    endfunction

endpackage

// File: rtl/rtc_timekeeper_if.sv
// Control, load, alarm and time/status signals of the time-of-day counter.
interface rtc_timekeeper_if;
    import rtc_pkg::*;

    logic             run;
    logic             load;
    logic [HRS_W-1:0] ld_hrs;
    logic [MS_W-1:0]  ld_min;
    logic [MS_W-1:0]  ld_sec;
    logic             alm_wr;
    logic [HRS_W-1:0] alm_hrs;
    logic [MS_W-1:0]  alm_min;
    logic             alm_en;
    logic [HRS_W-1:0] hrs;
    logic [MS_W-1:0]  min;
    logic [MS_W-1:0]  sec;
    logic             sec_tick;
    logic             day_wrap;
    logic             alarm;
    logic             load_err;

    modport master (
        output run, load, ld_hrs, ld_min, ld_sec, alm_wr, alm_hrs, alm_min, alm_en,
        input  hrs, min, sec, sec_tick, day_wrap, alarm, load_err
    );

    modport slave (
        input  run, load, ld_hrs, ld_min, ld_sec, alm_wr, alm_hrs, alm_min, alm_en,
        output hrs, min, sec, sec_tick, day_wrap, alarm, load_err
    );

endinterface

// File: rtl/mod_counter.sv
// Modulo-MOD counter with load, clear and enable; wrap flags the enabled MOD-1 -> 0 step.
module mod_counter #(
    parameter int unsigned MOD = 10,
    parameter int unsigned W   = 4
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         en,
    input  logic         clr,
    input  logic         ld,
    input  logic [W-1:0] d,
    output logic [W-1:0] q,
    output logic         wrap
);

    logic at_max;

    assign at_max = (q == W'(MOD - 1));
    assign wrap   = en && at_max;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            q <= '0;
        end else if (ld) begin
            q <= d;
        end else if (clr) begin
            q <= '0;
        end else if (en) begin
            q <= at_max ? '0 : q + W'(1);
        end
    end

endmodule

// File: rtl/rtc_timekeeper.sv
// Time-of-day counter: prescales clk to 1 s ticks, keeps hh:mm:ss, checked load and alarm.
module rtc_timekeeper
    import rtc_pkg::*;
#(
    parameter int unsigned TICKS_PER_SEC = 10,
    parameter int unsigned HRS_MOD       = 12
) (
    input logic              clk,
    input logic              rstn,
    rtc_timekeeper_if.slave  bus
);

    localparam int unsigned CNT_W = $clog2(TICKS_PER_SEC);

    rtc_time_t        ld_t;
    rtc_alarm_t       alm_q;
    logic [CNT_W-1:0] pre_q;
    logic [HRS_W-1:0] hrs_q, nxt_hrs;
    logic [MS_W-1:0]  min_q, nxt_min;
    logic [MS_W-1:0]  sec_q;
    logic             tick, ld_ok, adv;
    logic             sec_wrap, min_wrap, hrs_wrap;
    logic             alm_hit;
    logic             sec_tick_q, day_wrap_q, alarm_q, load_err_q;
    logic             unused_pre;

    // An accepted load overrides a coincident tick, so the time cascade only advances without one.
    assign ld_t  = {bus.ld_hrs, bus.ld_min, bus.ld_sec};
    assign ld_ok = bus.load && time_in_range(ld_t, HRS_MOD);
    assign adv   = tick && !ld_ok;

    // Only the wrap of the prescaler matters outside it.
    assign unused_pre = ^pre_q;

    mod_counter #(.MOD(TICKS_PER_SEC), .W(CNT_W)) u_pre (
        .clk  (clk),
        .rstn (rstn),
        .en   (bus.run),
        .clr  (ld_ok),
        .ld   (1'b0),
        .d    ({CNT_W{1'b0}}),
        .q    (pre_q),
        .wrap (tick)
    );

    mod_counter #(.MOD(SEC_MOD), .W(MS_W)) u_sec (
        .clk  (clk),
        .rstn (rstn),
        .en   (adv),
        .clr  (1'b0),
        .ld   (ld_ok),
        .d    (ld_t.sec),
        .q    (sec_q),
        .wrap (sec_wrap)
    );

    mod_counter #(.MOD(MIN_MOD), .W(MS_W)) u_min (
        .clk  (clk),
        .rstn (rstn),
        .en   (sec_wrap),
        .clr  (1'b0),
        .ld   (ld_ok),
        .d    (ld_t.min),
        .q    (min_q),
        .wrap (min_wrap)
    );

    mod_counter #(.MOD(HRS_MOD), .W(HRS_W)) u_hrs (
        .clk  (clk),
        .rstn (rstn),
        .en   (min_wrap),
        .clr  (1'b0),
        .ld   (ld_ok),
        .d    (ld_t.hrs),
        .q    (hrs_q),
        .wrap (hrs_wrap)
    );

    // Alarm compares against the time this tick is about to produce (seconds become 00).
    assign nxt_min = min_wrap ? MS_W'(0)  : (sec_wrap ? min_q + MS_W'(1)  : min_q);
    assign nxt_hrs = hrs_wrap ? HRS_W'(0) : (min_wrap ? hrs_q + HRS_W'(1) : hrs_q);
    assign alm_hit = bus.alm_en && sec_wrap && (nxt_hrs == alm_q.hrs) && (nxt_min == alm_q.min);

    always_ff @(posedge clk) begin
        if (!rstn) begin
            alm_q      <= '0;
            sec_tick_q <= 1'b0;
            day_wrap_q <= 1'b0;
            alarm_q    <= 1'b0;
            load_err_q <= 1'b0;
        end else begin
            if (bus.alm_wr) begin
                alm_q <= '{hrs: bus.alm_hrs, min: bus.alm_min};
            end
            sec_tick_q <= adv;
            day_wrap_q <= hrs_wrap;
            alarm_q    <= alm_hit;
            load_err_q <= bus.load && !ld_ok;
        end
    end

    assign bus.hrs      = hrs_q;
    assign bus.min      = min_q;
    assign bus.sec      = sec_q;
    assign bus.sec_tick = sec_tick_q;
    assign bus.day_wrap = day_wrap_q;
    assign bus.alarm    = alarm_q;
    assign bus.load_err = load_err_q;

endmodule

// File: tb/tb_rtc_timekeeper.sv
// Bench for rtc_timekeeper: 12 h and 24 h instances share one stimulus stream.
module tb_rtc_timekeeper;
    import rtc_pkg::*;

    logic clk = 1'b0;
    logic rstn;
    always #5 clk = ~clk;

    logic             run, load, alm_wr, alm_en;
    logic [HRS_W-1:0] ld_hrs, alm_hrs;
    logic [MS_W-1:0]  ld_min, ld_sec, alm_min;

    rtc_timekeeper_if i12 ();
    rtc_timekeeper_if i24 ();

    assign i12.run = run;         assign i24.run = run;
    assign i12.load = load;       assign i24.load = load;
    assign i12.ld_hrs = ld_hrs;   assign i24.ld_hrs = ld_hrs;
    assign i12.ld_min = ld_min;   assign i24.ld_min = ld_min;
    assign i12.ld_sec = ld_sec;   assign i24.ld_sec = ld_sec;
    assign i12.alm_wr = alm_wr;   assign i24.alm_wr = alm_wr;
    assign i12.alm_hrs = alm_hrs; assign i24.alm_hrs = alm_hrs;
    assign i12.alm_min = alm_min; assign i24.alm_min = alm_min;
    assign i12.alm_en = alm_en;   assign i24.alm_en = alm_en;

    rtc_timekeeper #(.TICKS_PER_SEC(10), .HRS_MOD(12)) dut12 (.clk(clk), .rstn(rstn), .bus(i12));
    rtc_timekeeper #(.TICKS_PER_SEC(10), .HRS_MOD(24)) dut24 (.clk(clk), .rstn(rstn), .bus(i24));

    int n_chk = 0;
    int n_err = 0;
    int cyc   = 0;
    int cnt_tick [2];
    int cnt_wrap [2];
    int cnt_lerr [2];
    int cnt_alm  [2];
    bit sb_on = 1'b0;

    typedef struct {
        int cyc;
        int t;
    } sb_t;
    sb_t sb_q[$];

    // sel: 0 = 12 h instance, 1 = 24 h instance; times written as hhmmss decimals
    typedef struct {
        int sel;
        int aen;
        int ld;
        int ncyc;
        int exp_t;
        int ticks;
        int wraps;
        int errs;
        int alms;
    } vec_t;
    vec_t vecs[15];
    vec_t exp_q[$];

    function automatic int tval(int sel);
        if (sel == 1) return int'(i24.hrs) * 10000 + int'(i24.min) * 100 + int'(i24.sec);
        return int'(i12.hrs) * 10000 + int'(i12.min) * 100 + int'(i12.sec);
    endfunction

    function automatic int outs(int sel);
        if (sel == 1) return tval(1) * 16 + int'({i24.sec_tick, i24.day_wrap, i24.alarm, i24.load_err});
        return tval(0) * 16 + int'({i12.sec_tick, i12.day_wrap, i12.alarm, i12.load_err});
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic clear_cnt();
        for (int k = 0; k < 2; k++) begin
            cnt_tick[k] = 0; cnt_wrap[k] = 0; cnt_lerr[k] = 0; cnt_alm[k] = 0;
        end
    endtask

    // Called right after a negedge; returns at the negedge following the load edge.
    task automatic do_load(input int v, input int aen);
        ld_hrs = 5'(v / 10000);
        ld_min = 6'((v / 100) % 100);
        ld_sec = 6'(v % 100);
        alm_en = (aen != 0);
        load   = 1'b1;
        clear_cnt();
        @(negedge clk);
        load = 1'b0;
    endtask

    // Pulse counters and the sec_tick scoreboard, sampled just after each rising edge.
    always begin
        @(posedge clk);
        #1;
        cyc = rstn ? cyc + 1 : 0;
        cnt_tick[0] += int'(i12.sec_tick); cnt_tick[1] += int'(i24.sec_tick);
        cnt_wrap[0] += int'(i12.day_wrap); cnt_wrap[1] += int'(i24.day_wrap);
        cnt_lerr[0] += int'(i12.load_err); cnt_lerr[1] += int'(i24.load_err);
        cnt_alm[0]  += int'(i12.alarm);    cnt_alm[1]  += int'(i24.alarm);
        if (sb_on && i12.sec_tick) begin
            sb_t e;
            if (sb_q.size() == 0) begin
                n_chk++;
                n_err++;
                $display("FAIL sb_unexpected_tick: got tick at cycle %0d, expected none", cyc);
            end else begin
                e = sb_q.pop_front();
                chk("sb_tick_cycle", cyc, e.cyc);
                chk("sb_tick_time", tval(0), e.t);
            end
        end
    end

    initial begin
        vecs[0]  = '{1, 1, 235959, 10,      0, 1, 1, 0, 0};
        vecs[1]  = '{0, 1,  10203, 10,  10204, 1, 0, 0, 0};
        vecs[2]  = '{0, 1, 120000,  0,  10204, 0, 0, 1, 0};
        vecs[3]  = '{0, 1,  56000,  0,  10204, 0, 0, 1, 0};
        vecs[4]  = '{0, 1,  51060,  0,  10204, 0, 0, 1, 0};
        vecs[5]  = '{0, 1, 115959, 10,      0, 1, 1, 0, 0};
        vecs[6]  = '{0, 1,   5959, 10,  10000, 1, 0, 0, 0};
        vecs[7]  = '{0, 1,  30458, 20,  30500, 2, 0, 0, 0};
        vecs[8]  = '{0, 1, 115859, 10, 115900, 1, 0, 0, 0};
        vecs[9]  = '{1, 1, 120000, 10, 120001, 1, 0, 0, 0};
        vecs[10] = '{1, 1, 240000,  0, 120001, 0, 0, 1, 0};
        vecs[11] = '{0, 1,  72959, 10,  73000, 1, 0, 0, 1};
        vecs[12] = '{0, 0,  72959, 10,  73000, 1, 0, 0, 0};
        vecs[13] = '{0, 1,  73000,  5,  73000, 0, 0, 0, 0};
        vecs[14] = '{0, 1,  73059, 10,  73100, 1, 0, 0, 0};

        rstn = 1'b0; run = 1'b1; load = 1'b0; alm_wr = 1'b0; alm_en = 1'b0;
        ld_hrs = '0; ld_min = '0; ld_sec = '0; alm_hrs = '0; alm_min = '0;
        clear_cnt();

        // Reset, then first ticks at cycles 10 and 20 after release
        sb_q.push_back('{10, 1});
        sb_q.push_back('{20, 2});
        sb_on = 1'b1;
        repeat (2) @(negedge clk);
        chk("reset_state_12h", outs(0), 0);
        chk("reset_state_24h", outs(1), 0);
        rstn = 1'b1;
        repeat (9) @(negedge clk);
        chk("before_first_tick", tval(0), 0);
        repeat (12) @(negedge clk);
        chk("sb_drained", sb_q.size(), 0);
        sb_on = 1'b0;

        alm_hrs = 5'd7; alm_min = 6'd30; alm_wr = 1'b1;
        @(negedge clk);
        alm_wr = 1'b0;

        foreach (vecs[i]) begin
            vec_t e;
            int   s;
            exp_q.push_back(vecs[i]);
            do_load(vecs[i].ld, vecs[i].aen);
            repeat (vecs[i].ncyc) @(negedge clk);
            e = exp_q.pop_front();
            s = e.sel;
            chk($sformatf("v%0d_time", i), tval(s), e.exp_t);
            chk($sformatf("v%0d_sec_tick", i), cnt_tick[s], e.ticks);
            chk($sformatf("v%0d_day_wrap", i), cnt_wrap[s], e.wraps);
            chk($sformatf("v%0d_load_err", i), cnt_lerr[s], e.errs);
            chk($sformatf("v%0d_alarm", i), cnt_alm[s], e.alms);
        end

        // Load landing on the prescaler-wrap edge suppresses that tick
        do_load(20000, 1);
        repeat (9) @(negedge clk);
        do_load(40506, 1);
        chk("wrap_load_time", tval(0), 40506);
        chk("wrap_load_no_tick", cnt_tick[0], 0);
        repeat (9) @(negedge clk);
        chk("wrap_load_hold", tval(0), 40506);
        @(negedge clk);
        chk("wrap_load_next", tval(0), 40507);
        chk("wrap_load_tick", cnt_tick[0], 1);

        // Stop mid-second for 25 cycles, then finish the remaining count
        repeat (4) @(negedge clk);
        run = 1'b0;
        repeat (25) @(negedge clk);
        chk("stop_frozen", tval(0), 40507);
        chk("stop_no_tick", cnt_tick[0], 1);
        run = 1'b1;
        repeat (5) @(negedge clk);
        chk("resume_remaining", tval(0), 40507);
        @(negedge clk);
        chk("resume_tick", tval(0), 40508);

        // Reset mid-count clears time, pulses and alarm registers
        do_load(51742, 1);
        repeat (3) @(negedge clk);
        rstn = 1'b0;
        @(negedge clk);
        chk("midrun_reset_12h", outs(0), 0);
        chk("midrun_reset_24h", outs(1), 0);
        rstn = 1'b1;
        do_load(115959, 1);
        repeat (10) @(negedge clk);
        chk("post_reset_time", tval(0), 0);
        chk("post_reset_day_wrap", cnt_wrap[0], 1);
        chk("post_reset_alarm_0000", cnt_alm[0], 1);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
